// File: rtl/hd44780_resp.sv
// hd44780_resp: HD44780-style LCD responder with DDRAM/CGRAM, address counter,
// busy-flag timing and power-on clear of the display RAM.
module hd44780_resp #(
    parameter int DATA_WIDTH  = 8,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  e_i,
    input  logic                  rs_i,
    input  logic                  rwb_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  data_oe_o,
    output logic                  busy_o,
    output logic [6:0]            ac_o,
    output logic [2:0]            disp_ctrl_o,
    output logic [2:0]            func_o,
    output logic                  err_o,
    input  logic [6:0]            dbg_addr_i,
    output logic [7:0]            dbg_data_o
);
    localparam int CW = $clog2(BUSY_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [6:0]            clr_addr, clr_nx;
    logic [DATA_WIDTH+2:0] sync1, sync2;
    logic                  e_d, e_s, rs_s, rwb_s;
    logic [DATA_WIDTH-1:0] d_s;
    logic                  rise, fall, wr, wr_ok, rd, busy, id, sel, rd_pend;
    logic [6:0]            ac, ac_inc, ac_dec, ac_step;
    logic [7:0]            ddram [128];
    logic [7:0]            cgram [64];
    logic [7:0]            rdata, dd_wd;
    logic [6:0]            dd_wa;
    logic                  dd_we, cg_we;

    // All bus inputs share one synchronizer so rs/rwb/data stay aligned with E
    assign {e_s, rs_s, rwb_s, d_s} = sync2;
    assign rise  = e_s & ~e_d;
    assign fall  = ~e_s & e_d;
    assign busy  = state != IDLE;
    assign wr    = fall & ~rwb_s;
    assign wr_ok = wr & ~busy & (rs_s | (d_s != '0));
    assign rd    = rise & rwb_s;

    // CGRAM addressing keeps AC[6] clear and wraps within 64 entries
    assign ac_inc  = sel ? {1'b0, ac[5:0] + 6'd1} : ac + 7'd1;
    assign ac_dec  = sel ? {1'b0, ac[5:0] - 6'd1} : ac - 7'd1;
    assign ac_step = id ? ac_inc : ac_dec;
    assign rdata   = sel ? cgram[ac[5:0]] : ddram[ac];

    assign dd_we = (state == CLEAR) | (wr_ok & rs_s & ~sel);
    assign dd_wa = (state == CLEAR) ? clr_addr : ac;
    assign dd_wd = (state == CLEAR) ? 8'h20 : d_s;
    assign cg_we = wr_ok & rs_s & sel;

    assign busy_o     = busy;
    assign ac_o       = ac;
    assign dbg_data_o = ddram[dbg_addr_i];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_nx   = clr_addr;
        if (wr_ok) begin
            state_nx = (!rs_s && d_s == 8'h01) ? CLEAR : EXEC;
            cnt_nx   = CW'(BUSY_CYCLES - 1);
            clr_nx   = '0;
        end else if (state == EXEC) begin
            state_nx = (cnt == '0) ? IDLE : EXEC;
            cnt_nx   = cnt - CW'(1);
        end else if (state == CLEAR) begin
            state_nx = (clr_addr == 7'h7f) ? EXEC : CLEAR;
            clr_nx   = clr_addr + 7'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= CLEAR;
            cnt      <= CW'(BUSY_CYCLES - 1);
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            clr_addr <= clr_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (dd_we) ddram[dd_wa] <= dd_wd;
        if (cg_we) cgram[ac[5:0]] <= d_s;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1       <= '0;
            sync2       <= '0;
            e_d         <= 1'b0;
            ac          <= '0;
            id          <= 1'b1;
            sel         <= 1'b0;
            disp_ctrl_o <= '0;
            func_o      <= 3'b100;
            err_o       <= 1'b0;
            data_out_o  <= '0;
            data_oe_o   <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            sync1 <= {e_i, rs_i, rwb_i, data_in_i};
            sync2 <= sync1;
            e_d   <= e_s;
            err_o <= err_o | (busy & (wr | (rd & rs_s)));
            if (rd) begin
                data_out_o <= rs_s ? (busy ? '0 : rdata) : {busy, ac};
                data_oe_o  <= 1'b1;
                rd_pend    <= rs_s & ~busy;
            end
            if (fall) begin
                data_oe_o <= 1'b0;
                rd_pend   <= 1'b0;
                if (rd_pend) ac <= ac_step;
            end
            if (wr_ok & rs_s) ac <= ac_step;
            if (wr_ok & ~rs_s) begin
                if (d_s[7]) begin
                    ac  <= d_s[6:0];
                    sel <= 1'b0;
                end else if (d_s[6]) begin
                    ac  <= {1'b0, d_s[5:0]};
                    sel <= 1'b1;
                end else if (d_s[5]) func_o <= d_s[4:2];
                else if (d_s[4]) ac <= d_s[3] ? ac : (d_s[2] ? ac_inc : ac_dec);
                else if (d_s[3]) disp_ctrl_o <= d_s[2:0];
                else if (d_s[2]) id <= d_s[1];
                else if (d_s[1]) ac <= '0;
            end
            if (state == CLEAR && clr_addr == 7'h7f) begin
                ac  <= '0;
                id  <= 1'b1;
                sel <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hd44780_resp.sv
// tb_hd44780_resp: directed and randomized bus accesses against a RAM/register
// model of the LCD responder.
module tb_hd44780_resp;
    localparam int BUSY  = 4;
    localparam int CLEAR = 128 + BUSY;

    logic       clk_i = 1'b0, rst_ni = 1'b0, e_i = 1'b0, rs_i = 1'b0, rwb_i = 1'b0;
    logic [7:0] data_in_i = '0, data_out_o, dbg_data_o;
    logic [6:0] ac_o, dbg_addr_i = '0;
    logic [2:0] disp_ctrl_o, func_o;
    logic       data_oe_o, busy_o, err_o;

    hd44780_resp #(.DATA_WIDTH(8), .BUSY_CYCLES(BUSY)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .e_i(e_i), .rs_i(rs_i), .rwb_i(rwb_i),
        .data_in_i(data_in_i), .data_out_o(data_out_o), .data_oe_o(data_oe_o),
        .busy_o(busy_o), .ac_o(ac_o), .disp_ctrl_o(disp_ctrl_o), .func_o(func_o),
        .err_o(err_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    always #5 clk_i = ~clk_i;

    int         pass_n = 0, tot_n = 0;
    logic [7:0] dd [128];
    logic [7:0] cg [64];
    int         m_ac = 0;
    bit         m_id = 1'b1, m_sel = 1'b0, m_err = 1'b0;
    logic [2:0] m_disp = '0, m_func = 3'b100;

    task automatic tick(int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state();
        chk("ac", ac_o, m_ac);
        chk("disp", disp_ctrl_o, m_disp);
        chk("func", func_o, m_func);
        chk("err", err_o, m_err);
    endtask

    task automatic peek(string tag, int a, int exp);
        dbg_addr_i = 7'(a);
        #1;
        chk(tag, dbg_data_o, exp);
    endtask

    task automatic model_reset();
        foreach (dd[i]) dd[i] = 8'h20;
        m_ac = 0; m_id = 1; m_sel = 0; m_err = 0; m_disp = 0; m_func = 3'b100;
    endtask

    // Address after one step up or down, wrapping within the selected RAM
    function automatic int stepped(int a, bit up);
        if (m_sel) return (a % 64 + (up ? 1 : 63)) % 64;
        return (a + (up ? 1 : 127)) % 128;
    endfunction

    // Applies an instruction to the model and returns the expected busy length
    function automatic int model_instr(int v);
        if (v >= 128) begin m_ac = v - 128; m_sel = 0; end
        else if (v >= 64) begin m_ac = v - 64; m_sel = 1; end
        else if (v >= 32) m_func = v[4:2];
        else if (v >= 16) begin if (!v[3]) m_ac = stepped(m_ac, v[2]); end
        else if (v >= 8) m_disp = v[2:0];
        else if (v >= 4) m_id = v[1];
        else if (v >= 2) m_ac = 0;
        else if (v == 1) begin
            foreach (dd[i]) dd[i] = 8'h20;
            m_ac = 0; m_id = 1; m_sel = 0;
            return CLEAR;
        end else return 0;
        return BUSY;
    endfunction

    task automatic bus_write(bit rs, int v, int exp_busy);
        int n = 0, w = 0;
        rs_i = rs; rwb_i = 0; data_in_i = 8'(v); e_i = 1;
        tick(2);
        e_i = 0;
        while (!busy_o && w < 8) begin tick(1); w++; end
        while (busy_o && n < 400) begin n++; tick(1); end
        chk("busy_len", n, exp_busy);
    endtask

    task automatic bus_read(bit rs, output logic [7:0] got, output logic oeh);
        rs_i = rs; rwb_i = 1; e_i = 1;
        tick(4);
        got = data_out_o; oeh = data_oe_o;
        e_i = 0;
        tick(5);
        chk("oe_after", data_oe_o, 0);
    endtask

    task automatic do_instr(int v);
        int e;
        e = model_instr(v);
        bus_write(0, v, e);
        chk_state();
    endtask

    task automatic do_data(int v);
        if (m_sel) cg[m_ac % 64] = 8'(v); else dd[m_ac] = 8'(v);
        m_ac = stepped(m_ac, m_id);
        bus_write(1, v, BUSY);
        chk_state();
    endtask

    task automatic do_read(bit rs);
        logic [7:0] got;
        logic       oeh;
        int         exp;
        if (rs) begin
            exp  = m_sel ? cg[m_ac % 64] : dd[m_ac];
            m_ac = stepped(m_ac, m_id);
        end else exp = m_ac;
        bus_read(rs, got, oeh);
        chk(rs ? "data_rd" : "bf_rd", got, exp);
        chk("oe_high", oeh, 1);
        chk_state();
    endtask

    task automatic release_and_count();
        int n = 0;
        rst_ni = 1;
        while (busy_o && n < 400) begin n++; tick(1); end
        chk("clear_busy_len", n, CLEAR);
    endtask

    initial begin
        logic [7:0] got;
        logic       oeh;
        tick(3);
        chk("rst_ac", ac_o, 0);
        chk("rst_disp", disp_ctrl_o, 0);
        chk("rst_func", func_o, 3'b100);
        chk("rst_err", err_o, 0);
        chk("rst_dout", data_out_o, 0);
        chk("rst_oe", data_oe_o, 0);
        release_and_count();
        model_reset();
        chk_state();
        peek("por_dd0", 0, 8'h20);
        peek("por_dd127", 127, 8'h20);

        do_instr(8'h90); do_data(8'h41); do_data(8'h42);
        peek("dd10", 8'h10, 8'h41);
        peek("dd11", 8'h11, 8'h42);
        chk("ac_12", ac_o, 8'h12);

        do_instr(8'h04); do_instr(8'h80); do_data(8'h55);
        peek("dd00", 0, 8'h55);
        chk("ac_wrap", ac_o, 8'h7f);

        do_instr(8'h0f); do_instr(8'h38);
        chk("disp_111", disp_ctrl_o, 3'b111);
        chk("func_110", func_o, 3'b110);

        do_instr(8'h06); do_instr(8'h7f); do_data(8'haa); do_data(8'hbb);
        do_instr(8'h7f);
        bus_read(1, got, oeh); m_ac = 0;
        chk("cg3f", got, 8'haa);
        bus_read(1, got, oeh); m_ac = 1;
        chk("cg00", got, 8'hbb);
        cg[63] = 8'haa; cg[0] = 8'hbb;
        chk_state();

        do_instr(8'h85);
        chk("oe_idle", data_oe_o, 0);
        bus_read(0, got, oeh);
        chk("bf_05", got, 8'h05);
        chk("bf_oe", oeh, 1);
        chk("bf_ac", ac_o, 8'h05);

        do_instr(8'h40);
        for (int i = 0; i < 64; i++) do_data($urandom_range(0, 255));

        for (int k = 0; k < 160; k++) begin
            int op, v;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                v = (k == 80) ? 1 : $urandom_range(0, 255);
                if (v == 1 && k != 80) v = 2;
                do_instr(v);
            end else if (op < 7) do_data($urandom_range(0, 255));
            else if (op < 9) do_read(1);
            else do_read(0);
        end

        // Back-to-back write, a data write that lands while busy, then BF read
        rs_i = 0; rwb_i = 0; data_in_i = 8'h83; e_i = 1;
        tick(1); e_i = 0;
        tick(1); rs_i = 1; data_in_i = 8'h77; e_i = 1;
        tick(1); e_i = 0;
        tick(1); rs_i = 0; rwb_i = 1; e_i = 1;
        tick(3);
        m_ac = 3; m_sel = 0; m_err = 1;
        chk("bf_busy", data_out_o, {1'b1, 7'(m_ac)});
        chk("err_set", err_o, 1);
        chk("ac_kept", ac_o, m_ac);
        e_i = 0;
        tick(12);
        chk("idle_again", busy_o, 0);
        chk_state();
        for (int i = 0; i < 128; i++) peek("ddram", i, dd[i]);

        // Reset in the middle of a clear restarts the power-on sequence
        rs_i = 0; rwb_i = 0; data_in_i = 8'h01; e_i = 1;
        tick(2); e_i = 0;
        tick(30);
        chk("mid_clear_busy", busy_o, 1);
        rst_ni = 0;
        tick(2);
        release_and_count();
        model_reset();
        chk_state();
        do_instr(8'h40);
        do_read(1);
        for (int i = 0; i < 128; i++) peek("ddram_rst", i, dd[i]);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
